// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg
// Shared definitions for the pipeline hazard/forwarding control slice.
//   FWD_RF / FWD_MEM / FWD_WB : EX operand-source encodings
//   REG_X0                    : the hard-wired zero register
//   sb_entry_t                : one scoreboard stage entry
//   sb_writes()               : "entry writes register r" test (x0 never matches)
//   fwd_pick()                : nearest-producer forwarding select
package cpu_pipe_pkg;

  // Scoreboard entries store rd zero-extended to this width, so the
  // controller supports register-address widths up to 8 bits.
  localparam int SB_RD_W = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [SB_RD_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } sb_entry_t;

  function automatic logic sb_writes(sb_entry_t e, logic [SB_RD_W-1:0] r);
    return e.valid && e.reg_write && (e.rd == r) && (r != REG_X0);
  endfunction

  // The youngest producer wins: EX/MEM result before MEM/WB result.
  function automatic logic [1:0] fwd_pick(logic ex_wr, logic mem_wr);
    if (ex_wr)  return FWD_MEM;
    if (mem_wr) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/cpu_pipe_ctrl_scoreboard.sv
// pipe_scoreboard
// Three-entry (EX, MEM, WB) shift register of in-flight destination
// registers, with per-stage "writes rs1/rs2" match outputs.
//   clk, rst            : clock, synchronous active-high reset
//   freeze              : hold every entry (variable-latency memory wait)
//   bubble              : load an invalid entry into EX instead of ID
//   id_*                : fields of the instruction currently in ID
//   rs1, rs2            : registers to match against every stage
//   ex/mem/wb_valid     : entry valid bits
//   ex_mem_read         : EX entry is a load
//   <stage>_wr_rs1/rs2  : stage entry writes the queried register
module pipe_scoreboard
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              bubble,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic              ex_mem_read,
  output logic              ex_wr_rs1,
  output logic              ex_wr_rs2,
  output logic              mem_wr_rs1,
  output logic              mem_wr_rs2,
  output logic              wb_wr_rs1,
  output logic              wb_wr_rs2
);

  sb_entry_t id_e;
  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;

  logic [SB_RD_W-1:0] rs1_x;
  logic [SB_RD_W-1:0] rs2_x;

  always_comb begin
    id_e           = '0;
    id_e.valid     = id_valid;
    id_e.rd        = SB_RD_W'(id_rd);
    id_e.reg_write = id_reg_write;
    id_e.mem_read  = id_mem_read;
  end

  assign rs1_x = SB_RD_W'(rs1);
  assign rs2_x = SB_RD_W'(rs2);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      ex_q  <= bubble ? '0 : id_e;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign mem_valid   = mem_q.valid;
  assign wb_valid    = wb_q.valid;
  assign ex_mem_read = ex_q.mem_read;

  assign ex_wr_rs1  = sb_writes(ex_q,  rs1_x);
  assign ex_wr_rs2  = sb_writes(ex_q,  rs2_x);
  assign mem_wr_rs1 = sb_writes(mem_q, rs1_x);
  assign mem_wr_rs2 = sb_writes(mem_q, rs2_x);
  assign wb_wr_rs1  = sb_writes(wb_q,  rs1_x);
  assign wb_wr_rs2  = sb_writes(wb_q,  rs2_x);

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// cpu_pipe_ctrl
// Hazard and pipeline-control unit for the IF/ID/EX/MEM/WB core.
//   clk, rst                     : clock, synchronous active-high reset
//   id_*                         : instruction currently in ID
//   ex_branch_taken              : EX resolved a taken branch/jump
//   mem_req, mem_ready           : MEM access in progress / completing
//   stall_if, stall_id           : hold PC / hold IF/ID
//   bubble_ex                    : load a NOP into ID/EX
//   flush_if_id                  : invalidate IF/ID
//   hold_mem                     : freeze EX/MEM and MEM/WB
//   fwd_a, fwd_b                 : registered EX operand selects
//   ex_valid, mem_valid, wb_valid: scoreboard valid bits
//   perf_stall_cnt/flush_cnt     : saturating event counters
// Control priority: memory wait > taken branch > data hazard > none.
// FWD_EN=1 interlocks only on load-use; FWD_EN=0 interlocks on any
// in-flight producer, since the register file is not write-through.
module cpu_pipe_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic              hold_mem,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  logic mem_wait;
  logic ex_mem_read;
  logic ex_wr_rs1, ex_wr_rs2;
  logic mem_wr_rs1, mem_wr_rs2;
  logic wb_wr_rs1, wb_wr_rs2;
  logic haz_rs1, haz_rs2, data_haz;

  assign mem_wait = mem_req & ~mem_ready;

  pipe_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .freeze       (mem_wait),
    .bubble       (bubble_ex),
    .id_valid     (id_valid),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .rs1          (id_rs1),
    .rs2          (id_rs2),
    .ex_valid     (ex_valid),
    .mem_valid    (mem_valid),
    .wb_valid     (wb_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_wr_rs1    (ex_wr_rs1),
    .ex_wr_rs2    (ex_wr_rs2),
    .mem_wr_rs1   (mem_wr_rs1),
    .mem_wr_rs2   (mem_wr_rs2),
    .wb_wr_rs1    (wb_wr_rs1),
    .wb_wr_rs2    (wb_wr_rs2)
  );

  // With forwarding only a load still in EX cannot supply its result in
  // time; without it any producer not yet retired blocks the reader.
  assign haz_rs1 = id_uses_rs1 & ((FWD_EN != 0) ? (ex_wr_rs1 & ex_mem_read)
                                                : (ex_wr_rs1 | mem_wr_rs1 | wb_wr_rs1));
  assign haz_rs2 = id_uses_rs2 & ((FWD_EN != 0) ? (ex_wr_rs2 & ex_mem_read)
                                                : (ex_wr_rs2 | mem_wr_rs2 | wb_wr_rs2));
  assign data_haz = id_valid & (haz_rs1 | haz_rs2);

  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    hold_mem    = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        // Whole pipe frozen; a taken branch stays in EX until release.
        hold_mem = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (ex_branch_taken) begin
        // PC must load the target, so no stall; the ID instruction is
        // squashed along with any hazard it raised.
        flush_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end else if (data_haz) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  if (FWD_EN != 0) begin : g_fwd
    logic [1:0] fwd_a_q;
    logic [1:0] fwd_b_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else if (!mem_wait) begin
        fwd_a_q <= bubble_ex ? FWD_RF : fwd_pick(ex_wr_rs1, mem_wr_rs1);
        fwd_b_q <= bubble_ex ? FWD_RF : fwd_pick(ex_wr_rs2, mem_wr_rs2);
      end
    end
    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
  end else begin : g_no_fwd
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
  end

  // stall_id is high exactly on data-hazard and memory-wait cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_id && (perf_stall_cnt != {CNT_W{1'b1}}))
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (flush_if_id && (perf_flush_cnt != {CNT_W{1'b1}}))
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// tb_cpu_pipe_ctrl
// Two controllers (index 0: forwarding, index 1: stall-only) with narrow
// counters so saturation is reachable. Each has its own stimulus; a
// behavioural model of in-flight producers predicts every output.
module tb_cpu_pipe_ctrl;

  localparam int AW = 5;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          br;
    logic          mreq;
    logic          mrdy;
  } stim_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stim_t in_s [2];

  logic          s_if [2], s_id [2], b_ex [2], f_ifid [2], h_mem [2];
  logic          v_ex [2], v_mem [2], v_wb [2];
  logic [1:0]    f_a [2], f_b [2];
  logic [CW-1:0] p_sc [2], p_fc [2];

  cpu_pipe_ctrl #(.REG_AW(AW), .FWD_EN(1), .CNT_W(CW)) u_dut_fwd (
    .clk(clk), .rst(rst),
    .id_valid(in_s[0].valid), .id_rs1(in_s[0].rs1), .id_rs2(in_s[0].rs2),
    .id_uses_rs1(in_s[0].u1), .id_uses_rs2(in_s[0].u2), .id_rd(in_s[0].rd),
    .id_reg_write(in_s[0].rw), .id_mem_read(in_s[0].mr),
    .ex_branch_taken(in_s[0].br), .mem_req(in_s[0].mreq), .mem_ready(in_s[0].mrdy),
    .stall_if(s_if[0]), .stall_id(s_id[0]), .bubble_ex(b_ex[0]),
    .flush_if_id(f_ifid[0]), .hold_mem(h_mem[0]), .fwd_a(f_a[0]), .fwd_b(f_b[0]),
    .ex_valid(v_ex[0]), .mem_valid(v_mem[0]), .wb_valid(v_wb[0]),
    .perf_stall_cnt(p_sc[0]), .perf_flush_cnt(p_fc[0])
  );

  cpu_pipe_ctrl #(.REG_AW(AW), .FWD_EN(0), .CNT_W(CW)) u_dut_stall (
    .clk(clk), .rst(rst),
    .id_valid(in_s[1].valid), .id_rs1(in_s[1].rs1), .id_rs2(in_s[1].rs2),
    .id_uses_rs1(in_s[1].u1), .id_uses_rs2(in_s[1].u2), .id_rd(in_s[1].rd),
    .id_reg_write(in_s[1].rw), .id_mem_read(in_s[1].mr),
    .ex_branch_taken(in_s[1].br), .mem_req(in_s[1].mreq), .mem_ready(in_s[1].mrdy),
    .stall_if(s_if[1]), .stall_id(s_id[1]), .bubble_ex(b_ex[1]),
    .flush_if_id(f_ifid[1]), .hold_mem(h_mem[1]), .fwd_a(f_a[1]), .fwd_b(f_b[1]),
    .ex_valid(v_ex[1]), .mem_valid(v_mem[1]), .wb_valid(v_wb[1]),
    .perf_stall_cnt(p_sc[1]), .perf_flush_cnt(p_fc[1])
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per controller: the instructions that left ID, youngest first
  // (slot 0 = one stage ahead of ID, slot 2 = three stages ahead).
  logic          mv  [2][3];
  logic          mrw [2][3];
  logic          mmr [2][3];
  logic [AW-1:0] mrd [2][3];
  logic [1:0]    mfa [2];
  logic [1:0]    mfb [2];
  int            msc [2];
  int            mfc [2];

  function automatic logic m_wr(int m, int s, logic [AW-1:0] r);
    return mv[m][s] && mrw[m][s] && (mrd[m][s] == r) && (r != 0);
  endfunction

  // Does a read of r from ID have to wait?
  function automatic logic m_src_haz(int m, logic [AW-1:0] r);
    if (m == 0) return m_wr(m, 0, r) && mmr[m][0];
    return m_wr(m, 0, r) || m_wr(m, 1, r) || m_wr(m, 2, r);
  endfunction

  // Expected {stall, bubble, flush, hold} from the priority rules.
  function automatic logic [3:0] m_ctrl(int m);
    stim_t v;
    v = in_s[m];
    if (rst) return 4'b0000;
    if (v.mreq && !v.mrdy) return 4'b1001;
    if (v.br) return 4'b0110;
    if (v.valid && ((v.u1 && m_src_haz(m, v.rs1)) || (v.u2 && m_src_haz(m, v.rs2))))
      return 4'b1100;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] m_fwd(int m, logic [AW-1:0] r);
    if (m == 1) return 2'b00;
    if (m_wr(m, 0, r)) return 2'b01;
    if (m_wr(m, 1, r)) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    logic [3:0] c;
    for (int m = 0; m < 2; m++) begin
      c = m_ctrl(m);
      if (rst) begin
        for (int s = 0; s < 3; s++) begin
          mv[m][s] = 1'b0; mrw[m][s] = 1'b0; mmr[m][s] = 1'b0; mrd[m][s] = '0;
        end
        mfa[m] = 2'b00; mfb[m] = 2'b00; msc[m] = 0; mfc[m] = 0;
      end else begin
        if (c[3] && msc[m] < CMAX) msc[m]++;
        if (c[1] && mfc[m] < CMAX) mfc[m]++;
        if (!c[0]) begin
          mfa[m] = c[2] ? 2'b00 : m_fwd(m, in_s[m].rs1);
          mfb[m] = c[2] ? 2'b00 : m_fwd(m, in_s[m].rs2);
          for (int s = 2; s > 0; s--) begin
            mv[m][s] = mv[m][s-1]; mrw[m][s] = mrw[m][s-1];
            mmr[m][s] = mmr[m][s-1]; mrd[m][s] = mrd[m][s-1];
          end
          mv[m][0]  = c[2] ? 1'b0 : in_s[m].valid;
          mrw[m][0] = in_s[m].rw;
          mmr[m][0] = in_s[m].mr;
          mrd[m][0] = in_s[m].rd;
        end
      end
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] c;
    for (int m = 0; m < 2; m++) begin
      c = m_ctrl(m);
      chk($sformatf("m%0d stall_if", m),    s_if[m],   c[3]);
      chk($sformatf("m%0d stall_id", m),    s_id[m],   c[3]);
      chk($sformatf("m%0d bubble_ex", m),   b_ex[m],   c[2]);
      chk($sformatf("m%0d flush_if_id", m), f_ifid[m], c[1]);
      chk($sformatf("m%0d hold_mem", m),    h_mem[m],  c[0]);
      chk($sformatf("m%0d fwd_a", m),       f_a[m],    mfa[m]);
      chk($sformatf("m%0d fwd_b", m),       f_b[m],    mfb[m]);
      chk($sformatf("m%0d ex_valid", m),    v_ex[m],   mv[m][0]);
      chk($sformatf("m%0d mem_valid", m),   v_mem[m],  mv[m][1]);
      chk($sformatf("m%0d wb_valid", m),    v_wb[m],   mv[m][2]);
      chk($sformatf("m%0d stall_cnt", m),   p_sc[m],   msc[m]);
      chk($sformatf("m%0d flush_cnt", m),   p_fc[m],   mfc[m]);
    end
  end

  // ---------------- driver ----------------
  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit rw, bit mr);
    stim_t s;
    s       = '0;
    s.valid = 1'b1;
    s.rd    = AW'(rd);
    s.rs1   = AW'(rs1);
    s.rs2   = AW'(rs2);
    s.u1    = u1;
    s.u2    = u2;
    s.rw    = rw;
    s.mr    = mr;
    return s;
  endfunction

  // One cycle: present v to controller m (the other idles), then wait
  // for the sampling point of that cycle.
  task automatic cyc(input int m, input stim_t v);
    @(posedge clk);
    #1;
    in_s[m]     = v;
    in_s[1 - m] = nop();
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    stim_t s;
    rst     = 1'b1;
    in_s[0] = nop();
    in_s[1] = nop();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ex_valid",  v_ex[0], 0);
    chk("reset stall_cnt", p_sc[1], 0);
    chk("reset fwd_a",     f_a[0],  0);

    // ALU producer then consumer at distance 1: forwarded, no stall.
    cyc(0, mk(5, 1, 2, 1, 1, 1, 0));
    cyc(0, mk(6, 5, 1, 1, 1, 1, 0));
    chk("alu dep no stall", s_if[0], 0);
    cyc(0, nop());
    chk("alu dep fwd_a", f_a[0], 2'b01);
    chk("alu dep fwd_b", f_b[0], 2'b00);

    // Load-use: one stall, then MEM/WB forwarding on both operands.
    cyc(0, mk(7, 0, 0, 0, 0, 1, 1));
    cyc(0, mk(8, 7, 7, 1, 1, 1, 0));
    chk("ldu stall_if",  s_if[0], 1);
    chk("ldu bubble_ex", b_ex[0], 1);
    cyc(0, mk(8, 7, 7, 1, 1, 1, 0));
    chk("ldu release",   s_if[0], 0);
    chk("ldu ex bubble", v_ex[0], 0);
    cyc(0, nop());
    chk("ldu fwd_a",     f_a[0],  2'b10);
    chk("ldu fwd_b",     f_b[0],  2'b10);
    chk("ldu stall_cnt", p_sc[0], 1);

    // Load-use coinciding with a taken branch: the branch wins.
    cyc(0, mk(9, 0, 0, 0, 0, 1, 1));
    s = mk(10, 9, 0, 1, 0, 1, 0);
    s.br = 1'b1;
    cyc(0, s);
    chk("br flush",    f_ifid[0], 1);
    chk("br bubble",   b_ex[0],   1);
    chk("br no stall", s_if[0],   0);
    cyc(0, nop());
    chk("br flush_cnt", p_fc[0], 1);
    chk("br stall_cnt", p_sc[0], 1);

    // Memory wait for 3 cycles with a pending branch.
    cyc(0, mk(12, 1, 2, 1, 1, 1, 0));
    cyc(0, mk(13, 12, 0, 1, 0, 1, 0));
    s = mk(14, 13, 0, 1, 0, 1, 0);
    s.br = 1'b1; s.mreq = 1'b1; s.mrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, s);
      chk("mw hold_mem",  h_mem[0],  1);
      chk("mw no flush",  f_ifid[0], 0);
      chk("mw fwd_a",     f_a[0],    2'b01);
      chk("mw mem_valid", v_mem[0],  1);
    end
    s.mrdy = 1'b1;
    cyc(0, s);
    chk("mw release hold", h_mem[0],  0);
    chk("mw branch taken", f_ifid[0], 1);
    cyc(0, nop());
    chk("mw stall_cnt", p_sc[0], 4);
    chk("mw flush_cnt", p_fc[0], 2);

    // x0 destination never creates a dependency.
    cyc(0, mk(0, 1, 2, 1, 1, 1, 1));
    cyc(0, mk(3, 0, 0, 1, 1, 1, 0));
    chk("x0 fwd mode stall", s_if[0], 0);
    cyc(0, nop());
    chk("x0 fwd_a", f_a[0], 2'b00);
    cyc(1, mk(0, 1, 2, 1, 1, 1, 0));
    cyc(1, mk(3, 0, 0, 1, 1, 1, 0));
    chk("x0 stall mode stall", s_if[1], 0);

    // Stall-only: distance-1 dependency costs 3 stall cycles.
    cyc(1, nop());
    cyc(1, nop());
    cyc(1, mk(5, 1, 2, 1, 1, 1, 0));
    for (int i = 0; i < 3; i++) begin
      cyc(1, mk(6, 5, 1, 1, 1, 1, 0));
      chk("so stall", s_if[1], 1);
    end
    cyc(1, mk(6, 5, 1, 1, 1, 1, 0));
    chk("so release", s_if[1], 0);
    cyc(1, nop());
    chk("so fwd_a",     f_a[1],  2'b00);
    chk("so ex_valid",  v_ex[1], 1);
    chk("so stall_cnt", p_sc[1], 3);

    // Reset in the middle of a stall.
    cyc(1, mk(7, 0, 0, 0, 0, 1, 1));
    cyc(1, mk(8, 7, 0, 1, 0, 1, 0));
    chk("pre-rst stall", s_if[1], 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst forces stall 0", s_if[1],   0);
    chk("rst forces bubble 0", b_ex[1],  0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst ex_valid",    v_ex[1],  0);
    chk("rst mem_valid",   v_mem[1], 0);
    chk("rst stall_cnt",   p_sc[1],  0);
    chk("rst flush_cnt 0", p_fc[0],  0);

    // Flush counter saturates at all-ones.
    s = nop();
    s.br = 1'b1;
    repeat (CMAX + 2) cyc(0, s);
    cyc(0, nop());
    chk("flush_cnt sat", p_fc[0], CMAX);

    repeat (3) cyc(0, nop());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
